// File: rtl/udp_header_streamer_if.sv
// Request and byte-stream signals of the UDP header streamer, bundled so the
// block and its environment connect through a single port.
interface udp_header_streamer_if #(
    parameter int PAYLOAD_WIDTH = 11
);
    logic [15:0]              fpga_port_i;
    logic [31:0]              fpga_ip_i;
    logic [47:0]              fpga_mac_i;
    logic [15:0]              host_port_i;
    logic [31:0]              host_ip_i;
    logic [47:0]              host_mac_i;
    logic [PAYLOAD_WIDTH-1:0] payload_bytes_i;
    logic                     hdr_valid_i;
    logic                     hdr_ready_o;
    logic [7:0]               m_data_o;
    logic                     m_valid_o;
    logic                     m_last_o;
    logic                     m_ready_i;
    logic [15:0]              ident_o;

    // master: the streamer itself; slave: whoever issues requests and sinks bytes
    modport master (
        input  fpga_port_i, fpga_ip_i, fpga_mac_i,
        input  host_port_i, host_ip_i, host_mac_i,
        input  payload_bytes_i, hdr_valid_i, m_ready_i,
        output hdr_ready_o, m_data_o, m_valid_o, m_last_o, ident_o
    );

    modport slave (
        output fpga_port_i, fpga_ip_i, fpga_mac_i,
        output host_port_i, host_ip_i, host_mac_i,
        output payload_bytes_i, hdr_valid_i, m_ready_i,
        input  hdr_ready_o, m_data_o, m_valid_o, m_last_o, ident_o
    );
endinterface

// File: rtl/udp_header_streamer.sv
// Captures one Ethernet/[802.1Q]/IPv4/UDP header request, computes the IPv4
// checksum over 12 cycles, then streams the header one byte per beat, MSB first.
module udp_header_streamer #(
    parameter int          PAYLOAD_WIDTH = 11,
    parameter logic [7:0]  TTL           = 8'h40,
    parameter int          VLAN_EN       = 0,
    parameter logic [15:0] VLAN_TCI      = 16'h0000,
    parameter int          ID_INCREMENT  = 1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    udp_header_streamer_if.master bus
);

    generate
        if (PAYLOAD_WIDTH < 1 || PAYLOAD_WIDTH > 16) begin : g_bad_width
            $error("udp_header_streamer: PAYLOAD_WIDTH must be in 1..16");
        end
        if (VLAN_EN != 0 && VLAN_EN != 1) begin : g_bad_vlan
            $error("udp_header_streamer: VLAN_EN must be 0 or 1");
        end
    endgenerate

    localparam int         HDR_BYTES = 42 + 4 * VLAN_EN;
    localparam int         HDR_BITS  = 8 * HDR_BYTES;
    localparam logic [5:0] LAST_IDX  = 6'(HDR_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CSUM, FOLD, SEND} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [19:0]              acc_q, acc_d;
    logic [5:0]               idx_q, idx_d;
    logic [15:0]              ident_q, ident_d;
    logic [15:0]              fpga_port_q, fpga_port_d;
    logic [31:0]              fpga_ip_q, fpga_ip_d;
    logic [47:0]              fpga_mac_q, fpga_mac_d;
    logic [15:0]              host_port_q, host_port_d;
    logic [31:0]              host_ip_q, host_ip_d;
    logic [47:0]              host_mac_q, host_mac_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;

    logic [15:0]   ipv4_len;
    logic [15:0]   udp_len;
    logic [15:0]   csum;
    logic [15:0]   csum_word;
    logic [239:0]  eth_tail;
    logic [HDR_BITS-1:0] hdr_vec;
    logic [7:0]    hdr_bytes [HDR_BYTES];

    // Lengths wrap mod 2^16 by construction of the 16-bit adders.
    assign ipv4_len = 16'd28 + 16'(payload_q);
    assign udp_len  = 16'd8 + 16'(payload_q);
    assign csum     = ~acc_q[15:0];

    always_comb begin
        csum_word = 16'h0000;
        case (cnt_q)
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = ipv4_len;
            4'd2:    csum_word = ident_q;
            4'd3:    csum_word = 16'h0000;
            4'd4:    csum_word = {TTL, 8'h11};
            4'd5:    csum_word = 16'h0000;
            4'd6:    csum_word = fpga_ip_q[31:16];
            4'd7:    csum_word = fpga_ip_q[15:0];
            4'd8:    csum_word = host_ip_q[31:16];
            4'd9:    csum_word = host_ip_q[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    assign eth_tail = {16'h0800,
                       8'h45, 8'h00, ipv4_len, ident_q, 16'h0000,
                       TTL, 8'h11, csum, fpga_ip_q, host_ip_q,
                       fpga_port_q, host_port_q, udp_len, 16'h0000};

    generate
        if (VLAN_EN != 0) begin : g_vlan
            assign hdr_vec = {host_mac_q, fpga_mac_q, 16'h8100, VLAN_TCI, eth_tail};
        end else begin : g_novlan
            assign hdr_vec = {host_mac_q, fpga_mac_q, eth_tail};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < HDR_BYTES; gi++) begin : g_bytes
            assign hdr_bytes[gi] = hdr_vec[HDR_BITS - 1 - 8 * gi -: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        ident_d     = ident_q;
        fpga_port_d = fpga_port_q;
        fpga_ip_d   = fpga_ip_q;
        fpga_mac_d  = fpga_mac_q;
        host_port_d = host_port_q;
        host_ip_d   = host_ip_q;
        host_mac_d  = host_mac_q;
        payload_d   = payload_q;
        case (state_q)
            IDLE: begin
                if (bus.hdr_valid_i) begin
                    fpga_port_d = bus.fpga_port_i;
                    fpga_ip_d   = bus.fpga_ip_i;
                    fpga_mac_d  = bus.fpga_mac_i;
                    host_port_d = bus.host_port_i;
                    host_ip_d   = bus.host_ip_i;
                    host_mac_d  = bus.host_mac_i;
                    payload_d   = bus.payload_bytes_i;
                    acc_d       = 20'd0;
                    cnt_d       = 4'd0;
                    idx_d       = 6'd0;
                    state_d     = CSUM;
                end
            end
            CSUM: begin
                acc_d = acc_q + {4'b0000, csum_word};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                // Two folds always suffice: ten 16-bit words cannot carry past bit 19.
                acc_d = {4'b0000, acc_q[15:0]} + {16'h0000, acc_q[19:16]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.m_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 6'd0;
                        ident_d = ident_q + 16'(ID_INCREMENT);
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            acc_q       <= 20'd0;
            idx_q       <= 6'd0;
            ident_q     <= 16'd0;
            fpga_port_q <= 16'd0;
            fpga_ip_q   <= 32'd0;
            fpga_mac_q  <= 48'd0;
            host_port_q <= 16'd0;
            host_ip_q   <= 32'd0;
            host_mac_q  <= 48'd0;
            payload_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            ident_q     <= ident_d;
            fpga_port_q <= fpga_port_d;
            fpga_ip_q   <= fpga_ip_d;
            fpga_mac_q  <= fpga_mac_d;
            host_port_q <= host_port_d;
            host_ip_q   <= host_ip_d;
            host_mac_q  <= host_mac_d;
            payload_q   <= payload_d;
        end
    end

    // Data and last derive only from registered state, so they hold during stalls.
    assign bus.hdr_ready_o = (state_q == IDLE);
    assign bus.m_valid_o   = (state_q == SEND);
    assign bus.m_last_o    = (state_q == SEND) && (idx_q == LAST_IDX);
    assign bus.m_data_o    = (state_q == SEND) ? hdr_bytes[idx_q] : 8'h00;
    assign bus.ident_o     = ident_q;

endmodule
